// File: rtl/bcd_count_ctrl.sv
// Command sequencer for a bank of cascaded decade counters: LOAD / RUN / STOP over valid/ready.
// Optional feature macro: BCD_CTRL_PAUSE_EN (adds the pause input that freezes RUN ticks).
module bcd_count_ctrl #(
    parameter int DIGITS = 4,
    parameter int RUN_W  = 16
) (
    input  logic                CLK,
    input  logic                MR,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [4*DIGITS-1:0] cmd_data,
`ifdef BCD_CTRL_PAUSE_EN
    input  logic                pause,
`endif
    input  logic [4*DIGITS-1:0] Q,
    output logic [4*DIGITS-1:0] P,
    output logic [DIGITS-1:0]   Load,
    output logic [DIGITS-1:0]   Enable,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                wrap
);

    typedef enum logic [1:0] {ST_IDLE, ST_LD, ST_RUN} state_t;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    state_t              r_state, w_state_nxt;
    logic [RUN_W-1:0]    r_remaining, w_remaining_nxt;
    logic [4*DIGITS-1:0] r_p, w_p_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err, w_err_nxt;
    logic                r_wrap, w_wrap_nxt;

    logic                w_pause;
    logic                w_tick;
    logic                w_accept;
    logic                w_bcd_ok;
    logic                w_all9;
    logic [RUN_W-1:0]    w_count;

`ifdef BCD_CTRL_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign cmd_ready = (r_state != ST_LD);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_tick    = (r_state == ST_RUN) && !w_pause;
    assign w_count   = cmd_data[RUN_W-1:0];

    // Carry chain: digit i counts only when every lower digit currently reads 9.
    always_comb begin
        logic w_carry;
        w_carry = w_tick;
        w_all9  = 1'b1;
        w_bcd_ok = 1'b1;
        Enable  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            Enable[i] = w_carry;
            w_carry   = w_carry && (Q[4*i +: 4] == 4'd9);
            w_all9    = w_all9 && (Q[4*i +: 4] == 4'd9);
            w_bcd_ok  = w_bcd_ok && (cmd_data[4*i +: 4] <= 4'd9);
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_p_nxt         = r_p;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_wrap_nxt      = w_tick && w_all9;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (cmd_op == OP_LOAD) begin
                        if (w_bcd_ok) begin
                            w_p_nxt     = cmd_data;
                            w_state_nxt = ST_LD;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (cmd_op == OP_RUN) begin
                        if (w_count == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_remaining_nxt = w_count;
                            w_state_nxt     = ST_RUN;
                        end
                    end
                end
            end
            ST_LD: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
            ST_RUN: begin
                if (w_tick) begin
                    w_remaining_nxt = r_remaining - RUN_W'(1);
                    if (r_remaining == RUN_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                // A STOP still lets the acceptance cycle count as a tick (handled above).
                if (w_accept) begin
                    if (cmd_op == OP_STOP) begin
                        w_state_nxt     = ST_IDLE;
                        w_done_nxt      = 1'b1;
                        w_remaining_nxt = '0;
                    end else if (cmd_op == OP_LOAD || cmd_op == OP_RUN) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK) begin
        if (MR) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_p         <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_p         <= w_p_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_wrap      <= w_wrap_nxt;
        end
    end

    assign P    = r_p;
    assign Load = {DIGITS{r_state == ST_LD}};
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign err  = r_err;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl with a behavioural 4-digit decade counter bank on Q.
// Build with BCD_CTRL_PAUSE_EN defined to also exercise the pause input.
module tb_bcd_count_ctrl;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    logic        CLK = 1'b0;
    logic        MR;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [15:0] Q;
    logic [15:0] P;
    logic [3:0]  Load;
    logic [3:0]  Enable;
    logic        busy, done, err, wrap;
`ifdef BCD_CTRL_PAUSE_EN
    logic        pause = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] q_bank;
    assign Q = q_bank;

    always #5 CLK = ~CLK;

    bcd_count_ctrl #(.DIGITS(4), .RUN_W(16)) dut (
        .CLK(CLK), .MR(MR),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
`ifdef BCD_CTRL_PAUSE_EN
        .pause(pause),
`endif
        .Q(Q), .P(P), .Load(Load), .Enable(Enable),
        .busy(busy), .done(done), .err(err), .wrap(wrap)
    );

    // External counter bank: same MR net, per-digit Load has priority over Enable.
    always @(posedge CLK) begin
        if (MR) begin
            q_bank <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (Load[i]) q_bank[4*i +: 4] <= P[4*i +: 4];
                else if (Enable[i]) q_bank[4*i +: 4] <= (q_bank[4*i +: 4] == 4'd9) ? 4'd0 : q_bank[4*i +: 4] + 4'd1;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Presents one command for one cycle; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [15:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
    endtask

    task automatic test_reset();
        MR = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if ({done, err, wrap} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {done, err, wrap}); end
        checks++; if ({Load, Enable} !== 8'h00) begin errors++; $display("FAIL rst_load_en got %h exp 00", {Load, Enable}); end
        checks++; if (P !== 16'h0000) begin errors++; $display("FAIL rst_p got %h exp 0000", P); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
        MR = 1'b0;
        step();
    endtask

    task automatic test_load();
        issue(OP_LOAD, 16'h0095);
        checks++; if (Load !== 4'hF) begin errors++; $display("FAIL ld_load got %h exp f", Load); end
        checks++; if (P !== 16'h0095) begin errors++; $display("FAIL ld_p got %h exp 0095", P); end
        checks++; if ({busy, cmd_ready, Enable} !== 6'b10_0000) begin errors++; $display("FAIL ld_busy_ready_en got %b exp 100000", {busy, cmd_ready, Enable}); end
        step();
        checks++; if ({done, Load} !== 5'b1_0000) begin errors++; $display("FAIL ld_done got %b exp 10000", {done, Load}); end
        checks++; if (Q !== 16'h0095) begin errors++; $display("FAIL ld_q got %h exp 0095", Q); end
        step();
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL ld_after got %b exp 00", {done, busy}); end
    endtask

    task automatic test_load_bad();
        issue(OP_LOAD, 16'h00A5);
        checks++; if ({err, busy, Load} !== 6'b10_0000) begin errors++; $display("FAIL bad_err got %b exp 100000", {err, busy, Load}); end
        checks++; if (P !== 16'h0095) begin errors++; $display("FAIL bad_p got %h exp 0095", P); end
        step();
        checks++; if ({err, done, Load} !== 6'b00_0000) begin errors++; $display("FAIL bad_after got %b exp 000000", {err, done, Load}); end
        checks++; if (Q !== 16'h0095) begin errors++; $display("FAIL bad_q got %h exp 0095", Q); end
    endtask

    task automatic test_idle_nop();
        issue(OP_STOP, 16'h0000);
        checks++; if ({done, err, busy} !== 3'b000) begin errors++; $display("FAIL idle_stop got %b exp 000", {done, err, busy}); end
        issue(OP_NOP, 16'h1234);
        checks++; if ({done, err, busy, Load, Enable} !== 11'b0) begin errors++; $display("FAIL idle_nop got %b exp 0", {done, err, busy, Load, Enable}); end
    endtask

    task automatic test_run();
        logic [3:0] exp_en [7] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h7, 4'h1, 4'h1};
        issue(OP_RUN, 16'd7);
        for (int k = 0; k < 7; k++) begin
            checks++; if ({busy, Enable} !== {1'b1, exp_en[k]}) begin errors++; $display("FAIL run_tick%0d got %b exp %b", k, {busy, Enable}, {1'b1, exp_en[k]}); end
            step();
        end
        checks++; if ({done, busy, Enable} !== 6'b10_0000) begin errors++; $display("FAIL run_done got %b exp 100000", {done, busy, Enable}); end
        checks++; if (Q !== 16'h0102) begin errors++; $display("FAIL run_q got %h exp 0102", Q); end
    endtask

    task automatic test_wrap();
        issue(OP_LOAD, 16'h9999);
        step(); step();
        checks++; if (Q !== 16'h9999) begin errors++; $display("FAIL wrap_pre_q got %h exp 9999", Q); end
        issue(OP_RUN, 16'd1);
        checks++; if (Enable !== 4'hF) begin errors++; $display("FAIL wrap_en got %h exp f", Enable); end
        step();
        checks++; if ({wrap, done, busy, Enable} !== 7'b110_0000) begin errors++; $display("FAIL wrap_pulse got %b exp 1100000", {wrap, done, busy, Enable}); end
        checks++; if (Q !== 16'h0000) begin errors++; $display("FAIL wrap_q got %h exp 0000", Q); end
        issue(OP_RUN, 16'd0);
        checks++; if ({done, wrap, busy, Enable} !== 7'b100_0000) begin errors++; $display("FAIL run0 got %b exp 1000000", {done, wrap, busy, Enable}); end
        step();
        checks++; if ({done, Enable, Q} !== 21'b0) begin errors++; $display("FAIL run0_after got %b exp 0", {done, Enable, Q}); end
    endtask

    task automatic test_stop();
        issue(OP_RUN, 16'd100);
        step(); step();
        issue(OP_LOAD, 16'h1234);
        checks++; if ({err, busy, cmd_ready, Enable[0]} !== 4'b1111) begin errors++; $display("FAIL stop_midload got %b exp 1111", {err, busy, cmd_ready, Enable[0]}); end
        for (int k = 0; k < 6; k++) step();
        checks++; if (Q !== 16'h0009) begin errors++; $display("FAIL stop_q9 got %h exp 0009", Q); end
        issue(OP_STOP, 16'h0000);
        checks++; if ({done, err, busy, Enable} !== 7'b100_0000) begin errors++; $display("FAIL stop_done got %b exp 1000000", {done, err, busy, Enable}); end
        checks++; if (Q !== 16'h0010) begin errors++; $display("FAIL stop_q got %h exp 0010", Q); end
        step();
        checks++; if ({done, Q} !== {1'b0, 16'h0010}) begin errors++; $display("FAIL stop_after got %h exp 0010", {done, Q}); end
    endtask

    task automatic test_mr_mid_run();
        issue(OP_RUN, 16'd5);
        checks++; if (Enable !== 4'h1) begin errors++; $display("FAIL mr_pre_en got %h exp 1", Enable); end
        MR = 1'b1;
        step();
        MR = 1'b0;
        checks++; if ({busy, done, Enable} !== 6'b0) begin errors++; $display("FAIL mr_state got %b exp 000000", {busy, done, Enable}); end
        checks++; if ({Q, P} !== 32'h0) begin errors++; $display("FAIL mr_qp got %h exp 0", {Q, P}); end
        step(); step();
        checks++; if ({busy, done, Enable} !== 6'b0) begin errors++; $display("FAIL mr_after got %b exp 000000", {busy, done, Enable}); end
    endtask

`ifdef BCD_CTRL_PAUSE_EN
    task automatic test_pause();
        int n_ticks = 0;
        issue(OP_RUN, 16'd5);
        for (int c = 0; c < 8; c++) begin
            pause = (c >= 2 && c <= 4);
            #1;
            if (Enable[0] === 1'b1) n_ticks++;
            checks++; if ({busy, cmd_ready} !== 2'b11) begin errors++; $display("FAIL pause_busy%0d got %b exp 11", c, {busy, cmd_ready}); end
            @(posedge CLK);
            #1;
        end
        pause = 1'b0;
        checks++; if (n_ticks != 5) begin errors++; $display("FAIL pause_ticks got %0d exp 5", n_ticks); end
        checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL pause_done got %b exp 10", {done, busy}); end
        checks++; if (Q !== 16'h0005) begin errors++; $display("FAIL pause_q got %h exp 0005", Q); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_load_bad();
        test_idle_nop();
        test_run();
        test_wrap();
        test_stop();
        test_mr_mid_run();
`ifdef BCD_CTRL_PAUSE_EN
        test_pause();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
